score_display: RTL and testbench

- Parametrised successor to the fixed two-digit score readout, which splits the score into tens and ones combinationally.
- Captures a binary score from the game level, keeps a high-score register, and converts the selected value to NUM_DIGITS BCD digits with a sequential double-dabble engine.
- Drives NUM_DIGITS active-low seven-segment displays (DE2 HEX polarity), with optional leading-zero blanking and overflow saturation.
- Sits in the top level between the level logic's score output and the HEX pins.

---
 rtl/space_invaders_pkg.sv | 31 +++
 rtl/seg7_encoder.sv | 32 +++
 rtl/score_display.sv | 224 ++++++++++++++++++++++
 tb/tb_score_display.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/space_invaders_pkg.sv
// Shared types and constants for the score readout: FSM states, the
// active-low seven-segment table and an elaboration-time parameter check.
package space_invaders_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        CONVERT = 2'd2,
        COMMIT  = 2'd3
    } disp_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Segment order is {g,f,e,d,c,b,a}; a zero bit lights the segment.
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    // True when 10^num_digits and the score width stay inside 32-bit integer range.
    function automatic bit pow10_fits(input int score_w, input int num_digits);
        longint p;
        p = 64'sd1;
        for (int i = 0; i < num_digits && i < 12; i++) begin
            p = p * 64'sd10;
        end
        return (score_w >= 2) && (score_w <= 31) &&
               (num_digits >= 1) && (p <= 64'sd2147483647);
    endfunction

endpackage

// File: rtl/seg7_encoder.sv
// One BCD digit to active-low seven-segment pattern, with a blank override.
module seg7_encoder
    import space_invaders_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Table lookup; non-decimal codes fall back to a dark digit.
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    seg = SEG_DIGIT[0];
                4'd1:    seg = SEG_DIGIT[1];
                4'd2:    seg = SEG_DIGIT[2];
                4'd3:    seg = SEG_DIGIT[3];
                4'd4:    seg = SEG_DIGIT[4];
                4'd5:    seg = SEG_DIGIT[5];
                4'd6:    seg = SEG_DIGIT[6];
                4'd7:    seg = SEG_DIGIT[7];
                4'd8:    seg = SEG_DIGIT[8];
                4'd9:    seg = SEG_DIGIT[9];
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/score_display.sv
// Score / high-score capture with a sequential double-dabble converter
// driving NUM_DIGITS active-low HEX displays.
module score_display
    import space_invaders_pkg::*;
#(
    parameter int SCORE_W       = 14,
    parameter int NUM_DIGITS    = 4,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    Clk,
    input  logic                    reset_n,
    input  logic [SCORE_W-1:0]      score_in,
    input  logic                    score_valid,
    input  logic                    show_high,
    input  logic                    clear_high,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic [SCORE_W-1:0]      high_score,
    output logic                    busy,
    output logic                    overflow
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SCORE_W - 1);

    function automatic logic [7*NUM_DIGITS-1:0] reset_pattern();
        logic [7*NUM_DIGITS-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            v[7*k +: 7] = ((k == 0) || (BLANK_LEADING == 0)) ? SEG_DIGIT[0] : SEG_BLANK;
        end
        return v;
    endfunction

    localparam logic [7*NUM_DIGITS-1:0] HEX_RESET = reset_pattern();

    generate
        if (!pow10_fits(SCORE_W, NUM_DIGITS)) begin : g_bad_params
            $error("score_display: SCORE_W/NUM_DIGITS out of supported range");
        end
    endgenerate

    disp_state_t               state_r, state_next_s;
    logic [SCORE_W-1:0]        cur_score_r;
    logic [SCORE_W-1:0]        high_score_r;
    logic                      show_high_r;
    logic                      pending_r, pending_next_s;
    logic                      busy_r, busy_next_s;
    logic                      overflow_r;
    logic [7*NUM_DIGITS-1:0]   hex_r;
    logic [SCORE_W-1:0]        bin_r;
    logic [BCD_W-1:0]          bcd_r;
    logic                      ovf_r;
    logic [CNT_W-1:0]          cnt_r;

    logic                      req_s, load_s, step_s, commit_s;
    logic [SCORE_W-1:0]        src_s;
    logic [BCD_W-1:0]          adj_s, bcd_shift_s;
    logic [SCORE_W-1:0]        bin_shift_s;
    logic                      carry_s;
    logic [3:0]                digit_s [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]     blank_s;
    logic [7*NUM_DIGITS-1:0]   seg_s;

    // Any new score, a clear, or a flip of the display source needs a fresh conversion.
    always_comb begin
        req_s = score_valid | clear_high | (show_high != show_high_r);
        src_s = show_high_r ? high_score_r : cur_score_r;
    end

    // Capture registers: current score, high score and the display-select copy.
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            cur_score_r  <= '0;
            high_score_r <= '0;
            show_high_r  <= 1'b0;
        end else begin
            show_high_r <= show_high;
            if (score_valid) begin
                cur_score_r <= score_in;
            end
            if (clear_high) begin
                high_score_r <= '0;
            end else if (score_valid && (score_in > high_score_r)) begin
                high_score_r <= score_in;
            end
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        commit_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (pending_r) begin
                    load_s       = 1'b1;
                    state_next_s = CONVERT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                load_s       = 1'b1;
                state_next_s = CONVERT;
            end
            CONVERT: begin
                step_s = 1'b1;
                if (cnt_r == LAST_STEP) begin
                    state_next_s = COMMIT;
                end else begin
                    state_next_s = CONVERT;
                end
            end
            COMMIT: begin
                commit_s = 1'b1;
                if (pending_r) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        // A request landing on the load edge still counts: the load used the old source.
        pending_next_s = req_s | (pending_r & ~load_s);
        busy_next_s    = (state_next_s != IDLE) | pending_next_s;
    end

    // FSM state, one-deep request flag and busy flag.
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            pending_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            pending_r <= pending_next_s;
            busy_r    <= busy_next_s;
        end
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, bin} left.
    always_comb begin
        adj_s = bcd_r;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (adj_s[4*k +: 4] >= 4'd5) begin
                adj_s[4*k +: 4] = adj_s[4*k +: 4] + 4'd3;
            end else begin
                adj_s[4*k +: 4] = adj_s[4*k +: 4];
            end
        end
        carry_s     = adj_s[BCD_W-1];
        bcd_shift_s = {adj_s[BCD_W-2:0], bin_r[SCORE_W-1]};
        bin_shift_s = {bin_r[SCORE_W-2:0], 1'b0};
    end

    // Converter datapath; the sticky bit remembers any digit carried off the top.
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            bin_r <= '0;
            bcd_r <= '0;
            ovf_r <= 1'b0;
            cnt_r <= '0;
        end else if (load_s) begin
            bin_r <= src_s;
            bcd_r <= '0;
            ovf_r <= 1'b0;
            cnt_r <= '0;
        end else if (step_s) begin
            bin_r <= bin_shift_s;
            bcd_r <= bcd_shift_s;
            ovf_r <= ovf_r | carry_s;
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Digit values and leading-zero blanking, scanned from the most significant digit.
    always_comb begin
        logic seen_nz;
        seen_nz = 1'b0;
        blank_s = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            digit_s[k] = ovf_r ? 4'd9 : bcd_r[4*k +: 4];
            if (bcd_r[4*k +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end else begin
                seen_nz = seen_nz;
            end
            blank_s[k] = (k != 0) && (BLANK_LEADING != 0) && !ovf_r && !seen_nz;
        end
    end

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
            seg7_encoder u_enc (
                .digit (digit_s[g]),
                .blank (blank_s[g]),
                .seg   (seg_s[7*g +: 7])
            );
        end
    endgenerate

    // Display registers change only in COMMIT, so the HEX pins never see partial results.
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            hex_r      <= HEX_RESET;
            overflow_r <= 1'b0;
        end else if (commit_s) begin
            hex_r      <= seg_s;
            overflow_r <= ovf_r;
        end
    end

    assign hex_out    = hex_r;
    assign high_score = high_score_r;
    assign busy       = busy_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_score_display.sv
// Directed plus randomized checks of score_display against an arithmetic
// reference model (decimal digits via / and %, high score via max).
module tb_score_display;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [13:0] score_in;
    logic        score_valid, show_high, clear_high;
    logic [27:0] hex_out;
    logic [13:0] high_score;
    logic        busy, overflow;

    int total = 0;
    int bad   = 0;
    int m_cur = 0, m_hs = 0;
    logic m_show = 1'b0;

    localparam logic [6:0] TB_SEG [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    score_display dut (
        .Clk         (clk),
        .reset_n     (reset_n),
        .score_in    (score_in),
        .score_valid (score_valid),
        .show_high   (show_high),
        .clear_high  (clear_high),
        .hex_out     (hex_out),
        .high_score  (high_score),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #10 clk = ~clk;

    function automatic logic [27:0] exp_hex(input int v);
        logic [27:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < 4; k++) begin
            if (v >= 10000)              r[7*k +: 7] = TB_SEG[9];
            else if (k > 0 && v < p)     r[7*k +: 7] = 7'h7F;
            else                         r[7*k +: 7] = TB_SEG[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request cycle, then the full conversion with latency and hold checks.
    task automatic do_req(input logic sv, input int s, input logic clr, input logic sh,
                          input string tag);
        logic [27:0] pre;
        bit held;
        int disp;
        pre = hex_out;
        score_valid = sv; score_in = 14'(s); clear_high = clr; show_high = sh;
        if (clr) m_hs = 0;
        else if (sv && s > m_hs) m_hs = s;
        if (sv) m_cur = s;
        m_show = sh;
        step();
        score_valid = 1'b0; clear_high = 1'b0;
        check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        held = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            if (hex_out !== pre || busy !== 1'b1) held = 1'b0;
        end
        check({tag, "_hold"}, {31'd0, held}, 32'd1);
        step();
        disp = m_show ? m_hs : m_cur;
        check({tag, "_hex"}, {4'd0, hex_out}, {4'd0, exp_hex(disp)});
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, disp >= 10000});
        check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
        check({tag, "_high"}, {18'd0, high_score}, 32'(m_hs));
    endtask

    initial begin
        logic [27:0] log_hex [$];
        int          log_cyc [$];
        logic [27:0] last;
        int          v;
        int          bvals [10] = '{0, 9, 10, 99, 100, 999, 1000, 9999, 10000, 16383};

        reset_n = 1'b0; score_in = '0; score_valid = 1'b0;
        show_high = 1'b0; clear_high = 1'b0;
        step(); step();
        reset_n = 1'b1;
        check("rst_hex",  {4'd0, hex_out}, {4'd0, exp_hex(0)});
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_high", {18'd0, high_score}, 32'd0);
        check("rst_ovf",  {31'd0, overflow}, 32'd0);
        step();

        do_req(1'b1, 1234, 1'b0, 1'b0, "basic1234");
        do_req(1'b0, 0, 1'b1, 1'b0, "clear1");

        // Back-to-back: 57, then 89 and 42 arrive while busy; only 57 and 42 commit.
        score_valid = 1'b1; score_in = 14'd57; step();
        score_valid = 1'b0; step();
        score_valid = 1'b1; score_in = 14'd89; step();
        score_valid = 1'b1; score_in = 14'd42; step();
        score_valid = 1'b0;
        m_cur = 42; m_hs = 89;
        last = hex_out;
        for (int c = 4; c <= 44; c++) begin
            step();
            if (hex_out !== last) begin
                log_hex.push_back(hex_out);
                log_cyc.push_back(c);
                last = hex_out;
            end
        end
        check("b2b_commits", 32'(log_hex.size()), 32'd2);
        if (log_hex.size() == 2) begin
            check("b2b_first",      {4'd0, log_hex[0]}, {4'd0, exp_hex(57)});
            check("b2b_first_cyc",  32'(log_cyc[0]), 32'd16);
            check("b2b_second",     {4'd0, log_hex[1]}, {4'd0, exp_hex(42)});
            check("b2b_second_cyc", 32'(log_cyc[1]), 32'd32);
        end
        check("b2b_high", {18'd0, high_score}, 32'd89);

        do_req(1'b1, 300, 1'b0, 1'b0, "hs300");
        do_req(1'b1, 120, 1'b0, 1'b0, "hs120");
        do_req(1'b0, 0, 1'b0, 1'b1, "show_high");
        do_req(1'b1, 500, 1'b1, 1'b1, "clr_and_500");
        do_req(1'b0, 0, 1'b0, 1'b0, "show_cur");

        do_req(1'b1, 10000, 1'b0, 1'b0, "ovf10000");
        do_req(1'b1, 9999, 1'b0, 1'b0, "max9999");

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 2) == 0) v = bvals[$urandom_range(0, 9)];
            else v = int'($urandom_range(0, 16383));
            do_req(1'b1, v, ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0), "rand");
        end

        // Reset at CONVERT cycle 5 aborts the conversion for good.
        show_high = 1'b0; step(); step(); step();
        score_valid = 1'b1; score_in = 14'd777; step();
        score_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        reset_n = 1'b0; step();
        reset_n = 1'b1;
        m_cur = 0; m_hs = 0;
        check("abort_hex",  {4'd0, hex_out}, {4'd0, exp_hex(0)});
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_high", {18'd0, high_score}, 32'd0);
        for (int i = 0; i < 20; i++) step();
        check("abort_no_commit", {4'd0, hex_out}, {4'd0, exp_hex(0)});
        check("abort_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
